// File: rtl/lookup_table_loader.sv
// Packs six stream words into one 192-bit lookup-RAM entry and writes entries at auto-incrementing addresses.
// Optional stream checksum is enabled by defining LOOKUP_LOADER_CHECKSUM_EN.
module lookup_table_loader #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ENTRY_WIDTH = 192
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_start,
    input  logic [ADDR_WIDTH-1:0]   load_base_addr,
    input  logic [ADDR_WIDTH:0]     load_count,
    input  logic [DATA_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [ADDR_WIDTH-1:0]   write_addr,
    output logic [ENTRY_WIDTH-1:0]  write_data,
    output logic                    write_enable,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_WIDTH:0]     entries_written,
    output logic [DATA_WIDTH-1:0]   checksum
);

    localparam int WORDS = ENTRY_WIDTH / DATA_WIDTH;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]             state;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [ADDR_WIDTH:0]    remaining;
    logic [IDX_W-1:0]       word_idx;
    logic [ENTRY_WIDTH-1:0] entry_buf;
    logic [ENTRY_WIDTH-1:0] entry_next;
    logic                   transfer;
    logic                   start_ok;

    // Handshake: a word moves when s_valid & s_ready at a rising edge; s_ready is a pure decode of state.
    assign s_ready      = (state == S_COLLECT);
    assign write_enable = (state == S_WRITE);
    assign busy         = (state == S_COLLECT) || (state == S_WRITE);
    assign done         = (state == S_DONE);

    assign transfer = s_valid & s_ready;
    assign start_ok = (state == S_IDLE) && load_start && (load_count != '0);

    always_comb begin
        entry_next = entry_buf;
        entry_next[int'(word_idx) * DATA_WIDTH +: DATA_WIDTH] = s_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cur_addr        <= '0;
            remaining       <= '0;
            word_idx        <= '0;
            entry_buf       <= '0;
            write_addr      <= '0;
            write_data      <= '0;
            entries_written <= '0;
            error           <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        if (load_count != '0) begin
                            cur_addr        <= load_base_addr;
                            remaining       <= load_count;
                            entries_written <= '0;
                            word_idx        <= '0;
                            error           <= 1'b0;
                            state           <= S_COLLECT;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                S_COLLECT: begin
                    if (load_start) error <= 1'b1;
                    if (transfer) begin
                        entry_buf <= entry_next;
                        if (word_idx == LAST_IDX) begin
                            // Output registers are loaded here so they are stable for the whole WRITE cycle.
                            word_idx   <= '0;
                            write_addr <= cur_addr;
                            write_data <= entry_next;
                            state      <= S_WRITE;
                        end else begin
                            word_idx <= word_idx + IDX_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (load_start) error <= 1'b1;
                    cur_addr        <= cur_addr + ADDR_WIDTH'(1);
                    entries_written <= entries_written + (ADDR_WIDTH + 1)'(1);
                    remaining       <= remaining - (ADDR_WIDTH + 1)'(1);
                    if (remaining == (ADDR_WIDTH + 1)'(1)) state <= S_DONE;
                    else                                   state <= S_COLLECT;
                end
                S_DONE: begin
                    if (load_start) error <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef LOOKUP_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clk) begin
        if (reset)         checksum_q <= '0;
        else if (start_ok) checksum_q <= '0;
        else if (transfer) checksum_q <= checksum_q ^ s_data;
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_lookup_table_loader.sv
// Randomized bench for lookup_table_loader: a word-list model predicts every RAM write, timing and status.
module tb_lookup_table_loader;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int EW = 192;
    localparam int WORDS = EW / DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_start;
    logic [AW-1:0] load_base_addr;
    logic [AW:0]   load_count;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] write_addr;
    logic [EW-1:0] write_data;
    logic          write_enable;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   entries_written;
    logic [DW-1:0] checksum;

    lookup_table_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ENTRY_WIDTH(EW)) dut (
        .clk(clk), .reset(reset), .load_start(load_start), .load_base_addr(load_base_addr),
        .load_count(load_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .write_addr(write_addr), .write_data(write_data), .write_enable(write_enable),
        .busy(busy), .done(done), .error(error), .entries_written(entries_written),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int start_cyc = 0;
    logic [AW+EW-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next predicted entry.
    always @(negedge clk) begin
        if (write_enable) begin
            check("ready_in_write", 256'(s_ready), 256'(0));
            if (exp_q.size() == 0) begin
                check("unexpected_write", 256'(1), 256'(0));
            end else begin
                logic [AW+EW-1:0] item;
                item = exp_q.pop_front();
                check("wr_addr", 256'(write_addr), 256'(item[AW+EW-1:EW]));
                check("wr_data", 256'(write_data), 256'(item[EW-1:0]));
            end
        end
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW-1:0] base, input logic [AW:0] count);
        load_start = 1'b1;
        load_base_addr = base;
        load_count = count;
        start_cyc = cyc;
        idle_cycle();
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        logic r;
        int n;
        s_valid = 1'b1;
        s_data = d;
        n = 0;
        do begin
            @(negedge clk);
            r = s_ready;
            idle_cycle();
            n++;
        end while (!r && n < 20);
        if (!r) check("send_timeout", 256'(0), 256'(1));
        s_valid = 1'b0;
    endtask

    // mode 1: words are seq0, seq0+1, ...; mode 0: random words.
    task automatic run_session(input logic [AW-1:0] base, input int count, input bit gaps,
                               input bit inject, input bit mode, input logic [DW-1:0] seq0);
        logic [DW-1:0] words[$];
        logic [EW-1:0] entry;
        logic [DW-1:0] exp_cs;
        int d0;
        int n;
        exp_cs = '0;
        for (int i = 0; i < count * WORDS; i++) begin
            words.push_back(mode ? seq0 + DW'(i) : DW'($urandom));
            exp_cs ^= words[i];
        end
        for (int e = 0; e < count; e++) begin
            entry = '0;
            for (int k = 0; k < WORDS; k++) entry[k*DW +: DW] = words[e*WORDS + k];
            exp_q.push_back({AW'(int'(base) + e), entry});
        end
`ifndef LOOKUP_LOADER_CHECKSUM_EN
        exp_cs = '0;
`endif
        d0 = done_cnt;
        pulse_start(base, (AW+1)'(count));
        check("start_ready", 256'(s_ready), 256'(1));
        check("start_busy", 256'(busy), 256'(1));
        check("start_error_clr", 256'(error), 256'(0));
        for (int i = 0; i < count * WORDS; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) idle_cycle();
            if (inject && i == 2) begin
                pulse_start(base ^ 8'h55, 9'd5);
                check("busy_start_error", 256'(error), 256'(1));
            end
            send_word(words[i]);
        end
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            idle_cycle();
            n++;
        end
        if (done_cnt == d0) check("done_timeout", 256'(0), 256'(1));
        repeat (3) idle_cycle();
        check("done_pulses", 256'(done_cnt - d0), 256'(1));
        check("entries_written", 256'(entries_written), 256'(count));
        check("busy_after", 256'(busy), 256'(0));
        check("ready_after", 256'(s_ready), 256'(0));
        check("pending_writes", 256'(exp_q.size()), 256'(0));
        check("error_after", 256'(error), 256'(inject));
        check("checksum", 256'(checksum), 256'(exp_cs));
        if (!gaps && !inject) check("session_latency", 256'(last_done_cyc - start_cyc), 256'(7 * count + 1));
    endtask

    initial begin
        reset = 1'b1;
        load_start = 1'b0;
        load_base_addr = '0;
        load_count = '0;
        s_data = '0;
        s_valid = 1'b0;
        repeat (3) idle_cycle();
        reset = 1'b0;
        idle_cycle();
        check("rst_ready", 256'(s_ready), 256'(0));
        check("rst_we", 256'(write_enable), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_error", 256'(error), 256'(0));
        check("rst_addr", 256'(write_addr), 256'(0));
        check("rst_data", 256'(write_data), 256'(0));
        check("rst_entries", 256'(entries_written), 256'(0));
        check("rst_checksum", 256'(checksum), 256'(0));

        // Words 0..B into 0x10/0x11, back-to-back.
        run_session(8'h10, 2, 1'b0, 1'b0, 1'b1, 32'h0);
        // Address wrap 0xFF -> 0x00 with random valid gaps.
        run_session(8'hFF, 2, 1'b1, 1'b0, 1'b0, 32'h0);

        // Zero count is rejected.
        load_start = 1'b1;
        load_count = '0;
        load_base_addr = 8'h33;
        idle_cycle();
        load_start = 1'b0;
        check("zero_count_error", 256'(error), 256'(1));
        check("zero_count_busy", 256'(busy), 256'(0));
        check("zero_count_ready", 256'(s_ready), 256'(0));

        // Start during COLLECT is flagged and ignored; the following session clears error.
        run_session(8'h20, 2, 1'b1, 1'b1, 1'b0, 32'h0);

        // Reset after 3 words of an entry discards it.
        pulse_start(8'h40, 9'd3);
        for (int i = 0; i < 3; i++) send_word(DW'($urandom));
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        check("mid_rst_ready", 256'(s_ready), 256'(0));
        check("mid_rst_we", 256'(write_enable), 256'(0));
        check("mid_rst_busy", 256'(busy), 256'(0));
        check("mid_rst_done", 256'(done), 256'(0));
        check("mid_rst_addr", 256'(write_addr), 256'(0));
        check("mid_rst_data", 256'(write_data), 256'(0));
        check("mid_rst_entries", 256'(entries_written), 256'(0));
        check("mid_rst_checksum", 256'(checksum), 256'(0));
        repeat (4) idle_cycle();

        // Words 1..6 give checksum 7 when the checksum is built in.
        run_session(8'h80, 1, 1'b0, 1'b0, 1'b1, 32'h1);

        for (int t = 0; t < 4; t++)
            run_session(AW'($urandom), $urandom_range(1, 5), 1'(t % 2), 1'b0, 1'b0, 32'h0);

        // Full-depth session, back-to-back.
        run_session(AW'($urandom), 256, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
